// File: rtl/uart_frame_sequencer.sv
// UART-side memory sequencer: writes a received frame to [RX_BASE..RX_LAST], runs the core, sends [TX_BASE..TX_LAST].
// Optional feature macro: UART_SEQ_REPEAT_EN (when defined, DONE rearms for the next frame).
module uart_frame_sequencer #(
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned RX_BASE     = 0,
  parameter int unsigned RX_LAST     = 65024,
  parameter int unsigned TX_BASE     = 65025,
  parameter int unsigned TX_LAST     = 81153,
  parameter int unsigned FRAME_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx_start,
  input  logic                   rx_busy,
  input  logic                   rx_done,
  input  logic                   tx_busy,
  input  logic                   tx_done,
  input  logic                   calc_finish,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_we,
  output logic                   mem_re,
  output logic                   uart_en,
  output logic                   tx_begin,
  output logic                   start_calc,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic [3:0]             dbg_state
);

  // Handshakes are level-sampled: each input is looked at only in the state that waits
  // on it, and a waited-for level that is already high is taken on the first cycle.

  localparam logic [ADDR_W-1:0] RX_BASE_A = ADDR_W'(RX_BASE);
  localparam logic [ADDR_W-1:0] RX_LAST_A = ADDR_W'(RX_LAST);
  localparam logic [ADDR_W-1:0] TX_BASE_A = ADDR_W'(TX_BASE);
  localparam logic [ADDR_W-1:0] TX_LAST_A = ADDR_W'(TX_LAST);

  if ((RX_BASE > RX_LAST) || (TX_BASE > TX_LAST) ||
      ((RX_LAST >> ADDR_W) != 0) || ((TX_LAST >> ADDR_W) != 0)) begin : g_bad_params
    $error("uart_frame_sequencer: address ranges must be ordered and fit in ADDR_W bits");
  end

  typedef enum logic [3:0] {
    RX_IDLE   = 4'd0,
    RX_DATA   = 4'd1,
    RX_WRITE  = 4'd2,
    RX_HOLD   = 4'd3,
    RX_ADV    = 4'd4,
    CALC      = 4'd5,
    CALC_WAIT = 4'd6,
    TX_READ   = 4'd7,
    TX_SETTLE = 4'd8,
    TX_START  = 4'd9,
    TX_XFER   = 4'd10,
    TX_ADV    = 4'd11,
    DONE      = 4'd12
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   we_q, we_d;
  logic                   re_q, re_d;
  logic                   en_q, en_d;
  logic                   begin_q, begin_d;
  logic                   calc_q, calc_d;
  logic                   done_q, done_d;
  logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      addr_q  <= RX_BASE_A;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      en_q    <= 1'b0;
      begin_q <= 1'b0;
      calc_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      re_q    <= re_d;
      en_q    <= en_d;
      begin_q <= begin_d;
      calc_q  <= calc_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    re_d    = re_q;
    en_d    = en_q;
    begin_d = begin_q;
    calc_d  = calc_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      RX_IDLE:   if (rx_start) state_d = RX_DATA;
      RX_DATA:   if (!rx_busy) state_d = RX_WRITE;
      RX_WRITE: begin
        we_d    = 1'b1;
        en_d    = 1'b1;
        state_d = RX_HOLD;
      end
      RX_HOLD:   state_d = RX_ADV;
      RX_ADV: begin
        if (rx_done) begin
          we_d = 1'b0;
          en_d = 1'b0;
          if (addr_q == RX_LAST_A) begin
            state_d = CALC;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = RX_IDLE;
          end
        end
      end
      CALC: begin
        calc_d  = 1'b1;
        state_d = CALC_WAIT;
      end
      CALC_WAIT: begin
        if (calc_finish) begin
          calc_d  = 1'b0;
          addr_d  = TX_BASE_A;
          state_d = TX_READ;
        end
      end
      TX_READ: begin
        re_d    = 1'b1;
        en_d    = 1'b1;
        state_d = TX_SETTLE;
      end
      TX_SETTLE: state_d = TX_START;
      // tx_begin is held until the TX core acknowledges by going busy.
      TX_START: begin
        if (tx_busy) begin
          begin_d = 1'b0;
          state_d = TX_XFER;
        end else begin
          begin_d = 1'b1;
        end
      end
      TX_XFER:   if (!tx_busy) state_d = TX_ADV;
      TX_ADV: begin
        re_d = 1'b0;
        en_d = 1'b0;
        if (tx_done) begin
          if (addr_q == TX_LAST_A) begin
            done_d  = 1'b1;
            cnt_d   = cnt_q + FRAME_CNT_W'(1);
            state_d = DONE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = TX_READ;
          end
        end
      end
      DONE: begin
`ifdef UART_SEQ_REPEAT_EN
        addr_d  = RX_BASE_A;
        state_d = RX_IDLE;
`else
        state_d = DONE;
`endif
      end
      default:   state_d = RX_IDLE;
    endcase
  end

  assign mem_addr   = addr_q;
  assign mem_we     = we_q;
  assign mem_re     = re_q;
  assign uart_en    = en_q;
  assign tx_begin   = begin_q;
  assign start_calc = calc_q;
  assign frame_done = done_q;
  assign frame_cnt  = cnt_q;
  assign dbg_state  = state_q;

endmodule
